// File: rtl/multiword_add_pkg.sv
// Shared constants for the multi-word adder: word width, FSM encoding, index sizing.
// Imported by multiword_add_sequencer and its datapath.
package multiword_add_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1 so a single-word build still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/RippleCarryAdder_32bit.sv
// 32-bit ripple carry adder built from a chain of full adders.
// Purely combinational: zero latency, no backpressure.
module RippleCarryAdder_32bit
    import multiword_add_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_cin,
    output logic [WORD_W-1:0] o_sum,
    output logic              o_cout
);

    logic [WORD_W:0] w_c;

    assign w_c[0] = i_cin;

    genvar g;
    generate
        for (g = 0; g < WORD_W; g++) begin : g_fa
            assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
            assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
        end
    endgenerate

    assign o_cout = w_c[WORD_W];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add (optionally subtract when MULTIWORD_ADD_SUB_EN is defined) using one 32-bit adder, LS word first.
// Latency: resp_valid rises NUM_WORDS cycles after the accepting edge; one op per NUM_WORDS+2 cycles.
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready, requests elsewhere are dropped.
module multiword_add_sequencer
    import multiword_add_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [NUM_WORDS*WORD_W-1:0] op_a,
    input  logic [NUM_WORDS*WORD_W-1:0] op_b,
    input  logic                        c_in,
`ifdef MULTIWORD_ADD_SUB_EN
    input  logic                        req_sub,
`endif
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [NUM_WORDS*WORD_W-1:0] result,
    output logic                        c_out,
    output logic                        overflow
);

    localparam int IDX_W = clog2(NUM_WORDS);
    localparam int TOT_W = NUM_WORDS * WORD_W;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TOT_W-1:0]      r_a;
    logic [TOT_W-1:0]      r_b;
    logic [TOT_W-1:0]      r_result;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_carry;
    logic                  r_c_out;
    logic                  r_overflow;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_init_carry;
    logic                  w_invert_b;
    logic [WORD_W-1:0]     w_a_word;
    logic [WORD_W-1:0]     w_b_word;
    logic [WORD_W-1:0]     w_sum;
    logic                  w_cout;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_last   = (r_idx == IDX_W'(NUM_WORDS - 1));

`ifdef MULTIWORD_ADD_SUB_EN
    logic r_sub;

    // Subtract is A + ~B + 1, so the incoming carry is overridden rather than combined.
    assign w_init_carry = req_sub ? 1'b1 : c_in;
    assign w_invert_b   = r_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= req_sub;
        end
    end
`else
    assign w_init_carry = c_in;
    assign w_invert_b   = 1'b0;
`endif

    assign w_a_word = r_a[r_idx*WORD_W +: WORD_W];
    assign w_b_word = w_invert_b ? ~r_b[r_idx*WORD_W +: WORD_W] : r_b[r_idx*WORD_W +: WORD_W];

    RippleCarryAdder_32bit u_adder (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)     w_state_nxt = DONE;
            DONE:    if (resp_ready) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= w_init_carry;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_result[r_idx*WORD_W +: WORD_W] <= w_sum;
            r_carry                          <= w_cout;
            if (w_last) begin
                // Signed overflow uses the effective (possibly inverted) B sign bit.
                r_c_out    <= w_cout;
                r_overflow <= (w_a_word[WORD_W-1] == w_b_word[WORD_W-1]) &&
                              (w_sum[WORD_W-1] != w_a_word[WORD_W-1]);
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == DONE);
    assign result     = r_result;
    assign c_out      = r_c_out;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer at NUM_WORDS=4; sub vectors run when MULTIWORD_ADD_SUB_EN is defined.
module tb_multiword_add_sequencer;

    localparam int NW = 4;
    localparam int W  = NW * 32;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         c_in;
`ifdef MULTIWORD_ADD_SUB_EN
    logic         req_sub;
`endif
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] result;
    logic         c_out;
    logic         overflow;

    int nvec;
    int nerr;
    int lat;

    multiword_add_sequencer #(.NUM_WORDS(NW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .c_in       (c_in),
`ifdef MULTIWORD_ADD_SUB_EN
        .req_sub    (req_sub),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .c_out      (c_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge, then scrambles operands to show they are not re-sampled.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub);
        op_a      = a;
        op_b      = b;
        c_in      = ci;
`ifdef MULTIWORD_ADD_SUB_EN
        req_sub   = sub;
`else
        if (sub) $display("note: sub requested in add-only build");
`endif
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        op_a      = {4{32'hDEAD_BEEF}};
        op_b      = {4{32'h1234_5678}};
        c_in      = ~ci;
`ifdef MULTIWORD_ADD_SUB_EN
        req_sub   = ~sub;
`endif
    endtask

    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (resp_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        int seen;
        logic [W-1:0] hold;

        nvec       = 0;
        nerr       = 0;
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        op_a       = '0;
        op_b       = '0;
        c_in       = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
        req_sub    = 1'b0;
`endif

        // Reset asserted mid-cycle takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_resp_valid", W'(resp_valid), W'(0));
        check("rst_result",     result,         W'(0));
        check("rst_c_out",      W'(c_out),      W'(0));
        check("rst_overflow",   W'(overflow),   W'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_req_ready",  W'(req_ready),  W'(1));

        // All-ones + 1 wraps to zero with carry out.
        start({W{1'b1}}, W'(1), 1'b0, 1'b0);
        check("run_req_ready", W'(req_ready), W'(0));
        wait_done(lat);
        check("wrap_latency",  W'(lat),      W'(4));
        check("wrap_result",   result,       W'(0));
        check("wrap_c_out",    W'(c_out),    W'(1));
        check("wrap_overflow", W'(overflow), W'(0));
        release_resp();

        // Max positive + 1 overflows into the sign bit.
        start({32'h7FFF_FFFF, {3{32'hFFFF_FFFF}}}, W'(1), 1'b0, 1'b0);
        wait_done(lat);
        check("pos_ovf_latency", W'(lat),      W'(4));
        check("pos_ovf_result",  result,       {32'h8000_0000, 96'h0});
        check("pos_ovf_c_out",   W'(c_out),    W'(0));
        check("pos_ovf_flag",    W'(overflow), W'(1));

        // Hold the response while hammering req_valid with fresh operands.
        hold = result;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0);
            op_a      = W'(i + 11);
            op_b      = W'(i * 3);
            c_in      = 1'b1;
            tick();
            check("bp_resp_valid", W'(resp_valid), W'(1));
            check("bp_req_ready",  W'(req_ready),  W'(0));
            check("bp_result",     result,         hold);
            check("bp_flags",      W'({c_out, overflow}), W'(2'b01));
        end
        req_valid = 1'b0;
        release_resp();
        check("bp_release_req_ready",  W'(req_ready),  W'(1));
        check("bp_release_resp_valid", W'(resp_valid), W'(0));
        tick();
        tick();
        check("bp_not_queued", W'(req_ready), W'(1));

        // Carry must cross a word boundary through the carry register.
        start({96'h0, 32'hFFFF_FFFF}, W'(1), 1'b1, 1'b0);
        wait_done(lat);
        check("xword_result", result,    {64'h0, 32'h1, 32'h1});
        check("xword_c_out",  W'(c_out), W'(0));
        release_resp();

        // Two most-negative values: zero sum, carry out and overflow.
        start({32'h8000_0000, 96'h0}, {32'h8000_0000, 96'h0}, 1'b0, 1'b0);
        wait_done(lat);
        check("neg_ovf_result", result,       W'(0));
        check("neg_ovf_flags",  W'({c_out, overflow}), W'(2'b11));
        release_resp();

        // Reset during RUN with idx at 2 discards the operation.
        start(W'(100), W'(200), 1'b0, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrun_resp_valid", W'(resp_valid), W'(0));
        check("midrun_req_ready",  W'(req_ready),  W'(1));
        check("midrun_result",     result,         W'(0));
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (resp_valid === 1'b1) seen++;
        end
        check("midrun_no_response", W'(seen), W'(0));

        start(W'(3), W'(4), 1'b1, 1'b0);
        wait_done(lat);
        check("post_rst_latency", W'(lat),      W'(4));
        check("post_rst_result",  result,       W'(8));
        check("post_rst_flags",   W'({c_out, overflow}), W'(2'b00));
        release_resp();

`ifdef MULTIWORD_ADD_SUB_EN
        // 5 - 7 borrows; c_in is ignored when subtracting.
        start(W'(5), W'(7), 1'b0, 1'b1);
        wait_done(lat);
        check("sub_neg_result", result,       {{3{32'hFFFF_FFFF}}, 32'hFFFF_FFFE});
        check("sub_neg_c_out",  W'(c_out),    W'(0));
        check("sub_neg_ovf",    W'(overflow), W'(0));
        release_resp();

        start(W'(7), W'(5), 1'b0, 1'b1);
        wait_done(lat);
        check("sub_pos_result", result,       W'(2));
        check("sub_pos_c_out",  W'(c_out),    W'(1));
        check("sub_pos_ovf",    W'(overflow), W'(0));
        release_resp();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-cycle wide-operand adder controller.
- Accepts NUM_WORDS×32-bit operands through a valid/ready request handshake.
- Time-shares one 32-bit ripple carry adder, one word per cycle, least-significant word first; the carry is registered between words.
- Returns the full sum, carry-out and signed-overflow flag through a valid/ready response handshake.
- Used by the ALU/datapath wherever arithmetic wider than 32 bits is needed.

Parameters:
NUM_WORDS, 4, number of 32-bit words per operand (≥1; result width NUM_WORDS*32)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request operands valid
req_ready  output  1  controller idle, can accept request
op_a  input  NUM_WORDS*32  operand A
op_b  input  NUM_WORDS*32  operand B
c_in  input  1  initial carry into word 0
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts result
result  output  NUM_WORDS*32  sum
c_out  output  1  carry out of the most significant word
overflow  output  1  two's-complement overflow of the full-width sum

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE; req_ready=1 (combinational from state); resp_valid=0; result=0; c_out=0; overflow=0; word index=0; carry register=0; operand registers=0.
- States: IDLE, RUN, DONE.
- req_ready = (state==IDLE). resp_valid = (state==DONE).
- IDLE: on req_valid&&req_ready at a clock edge:
  - latch op_a, op_b and c_in;
  - carry_reg<=c_in; idx<=0; state<=RUN.
- RUN, each cycle:
  - Adder inputs are A word[idx], B word[idx] and carry_reg.
  - result word[idx]<=adder sum; carry_reg<=adder carry.
  - If idx==NUM_WORDS-1: c_out<=adder carry; overflow<=(A_msb==B_msb)&&(sum_msb!=A_msb); state<=DONE.
  - Otherwise idx<=idx+1.
- DONE:
  - result, c_out and overflow are held stable.
  - On resp_ready: state<=IDLE. resp_valid falls and req_ready rises on the same edge.
  - No back-to-back accept in that cycle.
- Latency: resp_valid rises exactly NUM_WORDS cycles after the accepting edge. Minimum throughput is one operation per NUM_WORDS+2 cycles.
- Operand inputs are don't-care outside the accept cycle. Changes to op_a, op_b or c_in during RUN or DONE have no effect.
- req_valid outside IDLE is ignored. It is not queued.
- NUM_WORDS=1: RUN lasts one cycle, and the block degenerates to a registered 32-bit add.
- Result words not yet written in RUN hold their previous values. They are only observable once DONE is reached, by which time all words have been written.
- Reset mid-operation (RUN or DONE): all state clears immediately and asynchronously. The in-flight operation is discarded with no response.
- Arithmetic is modulo 2^(NUM_WORDS*32). No saturation.

Optional Feature:
- Macro: MULTIWORD_ADD_SUB_EN.
- Defined:
  - Adds input port req_sub (1 bit), latched on accept.
  - When req_sub=1, every B word is bitwise inverted before the adder and the initial carry is forced to 1 (c_in ignored), giving A−B.
  - c_out=1 means no borrow.
  - overflow uses the inverted B MSB.
- Undefined: the port is absent and the block only adds.

Decomposition:
- Shared package multiword_add_pkg:
  - WORD_W=32;
  - state encoding constants IDLE/RUN/DONE (2 bits);
  - index-width function clog2 for idx sizing.
- Single datapath sub-module: the existing 32-bit ripple carry adder (RippleCarryAdder_32bit), instantiated once.
- Word mux, B inversion, carry register and FSM stay in multiword_add_sequencer.

Test Plan (NUM_WORDS=4):
- Reset: assert rst_n=0 mid-cycle → all outputs 0 immediately, req_ready=1 after release.
- A=2^128−1, B=1, c_in=0 → result=0, c_out=1, overflow=0; resp_valid high exactly 4 cycles after the accept edge.
- A=0x7FFF…FFFF, B=1, c_in=0 → result=0x8000_0000_0000_0000_0000_0000_0000_0000, c_out=0, overflow=1.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid while pulsing req_valid with new operands → result/flags stable, req_ready=0, new request not accepted; after the resp_ready pulse, req_ready=1 the next cycle.
- Reset asserted during RUN at idx=2 → resp_valid never rises for that operation; the next request A=3, B=4, c_in=1 → result=8.
- With MULTIWORD_ADD_SUB_EN: A=5, B=7, req_sub=1 → result=0xFFFF…FFFE, c_out=0, overflow=0; A=7, B=5 → result=2, c_out=1.
